// File: rtl/aximm_leader_traffic_gen_if.sv
// AXI4 memory-mapped channel bundle between the leader traffic generator and the bridge.
interface aximm_leader_traffic_gen_if #(
  parameter int DWIDTH    = 128,
  parameter int ADDRWIDTH = 32
) ();
  logic [3:0]            awid;
  logic [ADDRWIDTH-1:0]  awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [3:0]            wid;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [3:0]            bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [3:0]            arid;
  logic [ADDRWIDTH-1:0]  araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [3:0]            rid;
  logic [DWIDTH-1:0]     rdata;
  logic                  rlast;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rlast, rresp, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rlast, rresp, rvalid, input rready
  );
endinterface

// File: rtl/aximm_leader_traffic_gen.sv
// AXI-MM leader traffic generator: writes one patterned burst, reads it back and checks every beat.
// state | meaning: IDLE wait start, AW/AR address phase, W data beats, B write resp, R read+check, DONE result pulse.
module aximm_leader_traffic_gen #(
  parameter int DWIDTH    = 128,
  parameter int ADDRWIDTH = 32,
  parameter int AXI_ID    = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [7:0]                 cfg_len,
  input  logic [ADDRWIDTH-1:0]       cfg_addr,
  input  logic [31:0]                cfg_seed,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [7:0]                 err_cnt,
  output logic                       timeout_err,
  aximm_leader_traffic_gen_if.master axi
);
  localparam int               LANES   = DWIDTH / 32;
  localparam logic [2:0]       SIZE    = 3'($clog2(DWIDTH / 8));
  localparam int               WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]   WD_LOAD = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  function automatic logic [DWIDTH-1:0] beat_pattern(input logic [31:0] seed, input logic [7:0] b);
    logic [DWIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++)
      v[32*k +: 32] = seed + {22'd0, b, 2'b00} + 32'(k);
    return v;
  endfunction

  state_t                state_q, state_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            len_q, len_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [31:0]           seed_q, seed_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [7:0]            err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [3:0]            id_q, id_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [DWIDTH/8-1:0]   wstrb_q, wstrb_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, active;
  logic r_bad, err_inc;
  logic [7:0] err_next;
  logic [DWIDTH-1:0] exp_beat;
  logic unused_ids;

  assign aw_hs    = awvalid_q & axi.awready;
  assign w_hs     = wvalid_q & axi.wready;
  assign b_hs     = bready_q & axi.bvalid;
  assign ar_hs    = arvalid_q & axi.arready;
  assign r_hs     = rready_q & axi.rvalid;
  assign any_hs   = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign active   = state_q inside {S_AW, S_W, S_B, S_AR, S_R};
  assign exp_beat = beat_pattern(seed_q, beat_q);
  assign r_bad    = (axi.rdata != exp_beat) || (axi.rresp != 2'b00) || (axi.rlast != (beat_q == len_q));
  assign err_inc  = (state_q == S_B && b_hs && axi.bresp != 2'b00) || (state_q == S_R && r_hs && r_bad);
  assign err_next = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  assign unused_ids = ^{axi.bid, axi.rid};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    len_d     = len_q;
    addr_d    = addr_q;
    seed_d    = seed_q;
    wd_d      = wd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_next;
    tmo_d     = tmo_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    wdata_d   = wdata_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    id_d      = id_q;
    size_d    = size_q;
    burst_d   = burst_q;
    wstrb_d   = wstrb_q;

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_AW;
        len_d     = cfg_len;
        addr_d    = cfg_addr;
        seed_d    = cfg_seed;
        err_d     = 8'd0;
        tmo_d     = 1'b0;
        pass_d    = 1'b0;
        busy_d    = 1'b1;
        awvalid_d = 1'b1;
        id_d      = 4'(AXI_ID);
        size_d    = SIZE;
        burst_d   = 2'b01;
        wstrb_d   = '1;
      end
      S_AW: if (aw_hs) begin
        state_d   = S_W;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b1;
        beat_d    = 8'd0;
        wdata_d   = beat_pattern(seed_q, 8'd0);
        wlast_d   = (len_q == 8'd0);
      end
      S_W: if (w_hs) begin
        if (wlast_q) begin
          state_d  = S_B;
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
        end else begin
          beat_d  = beat_q + 8'd1;
          wdata_d = beat_pattern(seed_q, beat_q + 8'd1);
          wlast_d = ((beat_q + 8'd1) == len_q);
        end
      end
      S_B: if (b_hs) begin
        state_d   = S_AR;
        bready_d  = 1'b0;
        arvalid_d = 1'b1;
      end
      S_AR: if (ar_hs) begin
        state_d   = S_R;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        beat_d    = 8'd0;
      end
      S_R: if (r_hs) begin
        beat_d = beat_q + 8'd1;
        // The last beat is judged by count, not by rlast; a wrong rlast is only scored.
        if (beat_q == len_q) begin
          state_d  = S_DONE;
          rready_d = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          pass_d   = (err_next == 8'd0) && !tmo_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!active || any_hs || state_d != state_q) begin
      wd_d = WD_LOAD;
    end else if (wd_q == '0) begin
      state_d   = S_DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      wlast_d   = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      tmo_d     = 1'b1;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      pass_d    = 1'b0;
      wd_d      = WD_LOAD;
    end else begin
      wd_d = wd_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      seed_q    <= '0;
      wd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      tmo_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= '0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      id_q      <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      seed_q    <= seed_d;
      wd_q      <= wd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      wdata_q   <= wdata_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      id_q      <= id_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_q;
  assign timeout_err = tmo_q;

  assign axi.awid    = id_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = burst_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wid     = id_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = wlast_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.arid    = id_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = burst_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
endmodule

// File: tb/tb_aximm_leader_traffic_gen.sv
// Bench for aximm_leader_traffic_gen: loopback follower model with fault/stall knobs and directed scenarios.
module tb_aximm_leader_traffic_gen;
  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int LANES = DW / 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [7:0]     cfg_len;
  logic [AW-1:0]  cfg_addr;
  logic [31:0]    cfg_seed;
  logic           busy, done, pass, timeout_err;
  logic [7:0]     err_cnt;

  aximm_leader_traffic_gen_if #(.DWIDTH(DW), .ADDRWIDTH(AW)) axi ();

  aximm_leader_traffic_gen #(.DWIDTH(DW), .ADDRWIDTH(AW), .AXI_ID(0), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_addr(cfg_addr),
    .cfg_seed(cfg_seed), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .timeout_err(timeout_err), .axi(axi)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]   m_seed;
  logic [AW-1:0] m_addr;
  int            m_len;
  int            corrupt_beat = -1;
  logic [1:0]    bresp_v = 2'b00;
  logic [1:0]    rresp_v = 2'b00;
  bit            stall = 1'b0;
  bit            ar_never = 1'b0;

  logic [DW-1:0] mem[$];
  int  w_idx, r_idx, r_left, aw_gap, w_gap, r_gap;
  bit  b_pend, aw_hold, w_hold, r_final;
  logic [DW-1:0] aw_snap, w_snap;
  int  exp_err, ar_high, aw_hs_cnt, w_hs_cnt, r_hs_cnt, wlast_cnt;

  function automatic logic [DW-1:0] pat(input logic [31:0] seed, input int b);
    logic [DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[32*k +: 32] = seed + 32'(4 * b + k);
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follower: loopback memory; drives at negedge, predicts the handshake at the next posedge.
  initial begin
    {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast} = '0;
    axi.bresp = '0; axi.bid = '0; axi.rdata = '0; axi.rresp = '0; axi.rid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast} = '0;
        axi.bresp = '0; axi.rdata = '0; axi.rresp = '0;
        w_idx = 0; r_idx = 0; r_left = 0; aw_gap = 0; w_gap = 0; r_gap = 0;
        b_pend = 0; aw_hold = 0; w_hold = 0; r_final = 0;
      end else begin
        if (r_final) begin
          check("done_after_last_r", {done, busy, axi.rready}, 3'b100);
          r_final = 0;
        end
        axi.awready = (aw_gap == 0);
        if (aw_gap > 0) aw_gap--;
        if (aw_hold) check("aw_stable", {axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid}, aw_snap);
        aw_hold = axi.awvalid && !axi.awready;
        aw_snap = {axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid};
        if (axi.awvalid && axi.awready) begin
          aw_hs_cnt++;
          aw_gap = stall ? int'($urandom_range(0, 5)) : 0;
        end

        axi.wready = (w_gap == 0);
        if (w_gap > 0) w_gap--;
        if (w_hold) check("w_stable", {axi.wvalid, axi.wlast, axi.wdata}, w_snap);
        w_hold = axi.wvalid && !axi.wready;
        w_snap = {axi.wvalid, axi.wlast, axi.wdata};
        if (axi.wvalid && axi.wready) begin
          check("w_data", axi.wdata, pat(m_seed, w_idx));
          check("w_last", axi.wlast, (w_idx == m_len));
          check("w_strb", axi.wstrb, {(DW/8){1'b1}});
          mem.push_back(axi.wdata);
          w_hs_cnt++;
          if (axi.wlast) begin wlast_cnt++; b_pend = 1; w_idx = 0; end
          else w_idx++;
          w_gap = stall ? int'($urandom_range(0, 5)) : 0;
        end

        axi.bvalid = b_pend;
        axi.bresp  = b_pend ? bresp_v : 2'b00;
        if (axi.bvalid && axi.bready) begin
          b_pend = 0;
          if (bresp_v != 2'b00) exp_err++;
        end

        axi.arready = !ar_never;
        if (axi.arvalid) ar_high++;
        if (axi.arvalid && axi.arready) begin
          check("ar_fields", {axi.araddr, axi.arlen, axi.arsize, axi.arburst}, {m_addr, 8'(m_len), 3'd4, 2'b01});
          r_left = int'(axi.arlen) + 1; r_idx = 0; r_gap = 0;
        end

        if (r_left > 0 && r_gap == 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = (r_idx < mem.size()) ? mem[r_idx] : '0;
          if (r_idx == corrupt_beat) axi.rdata[0] = ~axi.rdata[0];
          axi.rlast  = (r_idx == m_len);
          axi.rresp  = rresp_v;
        end else begin
          axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
          if (r_gap > 0) r_gap--;
        end
        if (axi.rvalid && axi.rready) begin
          if (r_idx == corrupt_beat || rresp_v != 2'b00) exp_err++;
          r_idx++; r_left--; r_hs_cnt++;
          if (r_left == 0) r_final = 1;
          r_gap = stall ? int'($urandom_range(0, 5)) : 0;
        end
      end
    end
  end

  task automatic kick(input logic [7:0] len, input logic [AW-1:0] addr, input logic [31:0] seed);
    m_len = int'(len); m_addr = addr; m_seed = seed; exp_err = 0;
    ar_high = 0; aw_hs_cnt = 0; w_hs_cnt = 0; r_hs_cnt = 0; wlast_cnt = 0;
    aw_gap = 0; w_gap = 0; r_gap = 0; w_idx = 0;
    mem.delete();
    @(negedge clk);
    cfg_len = len; cfg_addr = addr; cfg_seed = seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy_awvalid", {busy, axi.awvalid}, 2'b11);
    check("start_aw_fields", {axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid}, {addr, len, 3'd4, 2'b01, 4'd0});
    check("start_cleared", {pass, err_cnt, timeout_err}, '0);
  endtask

  task automatic run_until_done(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic check_result(input string tag, input bit exp_tmo);
    int e;
    e = (exp_err > 255) ? 255 : exp_err;
    check({tag, "_err_cnt"}, err_cnt, 8'(e));
    check({tag, "_pass"}, pass, (e == 0 && !exp_tmo));
    check({tag, "_timeout"}, timeout_err, exp_tmo);
    @(negedge clk);
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_addr = '0; cfg_seed = '0;
    repeat (3) @(negedge clk);
    check("rst_status", {busy, done, pass, err_cnt, timeout_err}, '0);
    check("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}, '0);
    check("rst_data", {axi.awaddr, axi.awid, axi.wdata}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    kick(8'd7, 32'h10, 32'h1000_0000);
    run_until_done(500, "basic");
    check("basic_beats", {32'(w_hs_cnt), 32'(r_hs_cnt), 32'(wlast_cnt)}, {32'd8, 32'd8, 32'd1});
    check("basic_b0_lane0", mem[0][31:0], 32'h1000_0000);
    check("basic_b7_lane3", mem[7][127:96], 32'h1000_001F);
    check_result("basic", 1'b0);

    corrupt_beat = 3;
    kick(8'd7, $urandom, $urandom);
    run_until_done(500, "corrupt");
    check_result("corrupt", 1'b0);
    corrupt_beat = -1;

    kick(8'd0, $urandom, $urandom);
    run_until_done(200, "single");
    check("single_beats", {32'(w_hs_cnt), 32'(r_hs_cnt), 32'(wlast_cnt)}, {32'd1, 32'd1, 32'd1});
    check_result("single", 1'b0);

    stall = 1'b1;
    kick(8'd15, $urandom, $urandom);
    run_until_done(2000, "stall");
    check("stall_beats", {32'(w_hs_cnt), 32'(r_hs_cnt)}, {32'd16, 32'd16});
    check_result("stall", 1'b0);
    stall = 1'b0;

    ar_never = 1'b1;
    kick(8'd3, $urandom, $urandom);
    run_until_done(1500, "timeout");
    check("timeout_ar_window", 32'(ar_high), 32'd1024);
    check("timeout_arvalid_low", axi.arvalid, 1'b0);
    check_result("timeout", 1'b1);
    ar_never = 1'b0;

    bresp_v = 2'b10; rresp_v = 2'b10;
    kick(8'd3, $urandom, $urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (axi.rready) break;
    end
    check("resp_in_r", axi.rready, 1'b1);
    cfg_len = 8'd0; cfg_addr = 32'h999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_done(200, "resp");
    check("resp_model_err", 32'(exp_err), 32'd5);
    check_result("resp", 1'b0);
    repeat (4) @(negedge clk);
    check("resp_restart_ignored", {busy, axi.awvalid}, 2'b00);
    bresp_v = 2'b00; rresp_v = 2'b00;

    kick(8'd15, $urandom, $urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (axi.wvalid && w_hs_cnt >= 3) break;
    end
    check("rstmid_in_w", axi.wvalid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_status", {busy, done, pass, err_cnt, timeout_err}, '0);
    check("rstmid_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}, '0);
    check("rstmid_data", {axi.awaddr, axi.awlen, axi.wdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    w_hs_cnt = 0;
    repeat (20) @(negedge clk);
    check("rstmid_quiet", {busy, axi.awvalid, axi.wvalid, 32'(w_hs_cnt)}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
